// File: rtl/pulp_clock_gate_ctrl.sv
// pulp_clock_gate_ctrl: idle-detect controller driving the enable of a downstream clock gate
module pulp_clock_gate_ctrl #(
    parameter int IDLE_CNT_WIDTH = 8,
    parameter int WAKE_LAT       = 2,
    parameter int STAT_WIDTH     = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_auto_i,
    input  logic                      test_en_i,
    input  logic                      busy_i,
    input  logic                      wake_req_i,
    input  logic [IDLE_CNT_WIDTH-1:0] idle_thresh_i,
    input  logic                      stat_clr_i,
    output logic                      clk_en_o,
    output logic                      gated_o,
    output logic                      wake_ack_o,
    output logic [STAT_WIDTH-1:0]     gated_cnt_o
);
    typedef enum logic [1:0] {RUN, COUNT, GATED, WAKE} state_t;
    localparam logic [3:0] WAKE_LAST = 4'(WAKE_LAT - 1);
    state_t                    state;
    logic [IDLE_CNT_WIDTH-1:0] idle_cnt;
    logic [3:0]                wake_cnt;
    logic                      idle;
    assign idle = en_auto_i & ~test_en_i & ~busy_i & ~wake_req_i;
    // state machine with outputs registered alongside each transition so the enable never glitches
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= RUN;
            idle_cnt   <= '0;
            wake_cnt   <= '0;
            clk_en_o   <= 1'b1;
            gated_o    <= 1'b0;
            wake_ack_o <= 1'b1;
        end else begin
            case (state)
                RUN: if (idle) begin
                    state      <= COUNT;
                    idle_cnt   <= '0;
                    wake_ack_o <= 1'b0;
                end
                COUNT: if (!idle) begin
                    state      <= RUN;
                    idle_cnt   <= '0;
                    wake_ack_o <= 1'b1;
                end else if (idle_cnt >= idle_thresh_i) begin
                    state    <= GATED;
                    clk_en_o <= 1'b0;
                    gated_o  <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
                GATED: if (!idle) begin
                    state    <= WAKE;
                    wake_cnt <= '0;
                    clk_en_o <= 1'b1;
                    gated_o  <= 1'b0;
                end
                WAKE: if (wake_cnt == WAKE_LAST) begin
                    state      <= RUN;
                    wake_ack_o <= 1'b1;
                end else begin
                    wake_cnt <= wake_cnt + 1'b1;
                end
                default: begin
                    state      <= RUN;
                    clk_en_o   <= 1'b1;
                    gated_o    <= 1'b0;
                    wake_ack_o <= 1'b1;
                end
            endcase
        end
    end
    // saturating count of gated cycles, clear wins over increment
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) gated_cnt_o <= '0;
        else if (stat_clr_i) gated_cnt_o <= '0;
        else if (gated_o && !(&gated_cnt_o)) gated_cnt_o <= gated_cnt_o + 1'b1;
    end
endmodule

// File: tb/tb_pulp_clock_gate_ctrl.sv
// tb_pulp_clock_gate_ctrl: randomized and directed checks against an idle-streak model
module tb_pulp_clock_gate_ctrl;
    localparam int IW = 8;
    localparam int WL = 2;
    localparam int SW = 4;
    localparam int SMAX = (1 << SW) - 1;
    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          en_auto_i = 1'b0;
    logic          test_en_i = 1'b0;
    logic          busy_i = 1'b0;
    logic          wake_req_i = 1'b0;
    logic [IW-1:0] idle_thresh_i = '0;
    logic          stat_clr_i = 1'b0;
    logic          clk_en_o, gated_o, wake_ack_o;
    logic [SW-1:0] gated_cnt_o;
    int n_cmp = 0;
    int n_err = 0;
    int m_gated, m_wake, m_streak, m_stat;
    logic m_idle;

    pulp_clock_gate_ctrl #(.IDLE_CNT_WIDTH(IW), .WAKE_LAT(WL), .STAT_WIDTH(SW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_auto_i(en_auto_i), .test_en_i(test_en_i),
        .busy_i(busy_i), .wake_req_i(wake_req_i), .idle_thresh_i(idle_thresh_i),
        .stat_clr_i(stat_clr_i), .clk_en_o(clk_en_o), .gated_o(gated_o),
        .wake_ack_o(wake_ack_o), .gated_cnt_o(gated_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    assign m_idle = en_auto_i & ~test_en_i & ~busy_i & ~wake_req_i;

    // model: m_streak counts consecutive idle samples while running; gating happens once
    // the streak already exceeds the threshold; waking takes WL edges before acknowledge
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_gated <= 0; m_wake <= 0; m_streak <= 0; m_stat <= 0;
        end else begin
            m_stat <= stat_clr_i ? 0 : (m_gated != 0 && m_stat < SMAX) ? m_stat + 1 : m_stat;
            if (m_gated != 0) begin
                if (!m_idle) begin m_gated <= 0; m_wake <= WL; end
            end else if (m_wake > 0) m_wake <= m_wake - 1;
            else if (!m_idle) m_streak <= 0;
            else if (m_streak >= int'(idle_thresh_i) + 1) begin m_gated <= 1; m_streak <= 0; end
            else m_streak <= m_streak + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // every-cycle comparison of the DUT against the model, away from the active edge
    always @(negedge clk_i) begin
        chk("clk_en", int'(clk_en_o), m_gated == 0 ? 1 : 0);
        chk("gated", int'(gated_o), m_gated);
        chk("wake_ack", int'(wake_ack_o), (m_gated == 0 && m_wake == 0 && m_streak == 0) ? 1 : 0);
        chk("gated_cnt", int'(gated_cnt_o), m_stat);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        step(2);
        chk("rst_clk_en", int'(clk_en_o), 1);
        chk("rst_ack", int'(wake_ack_o), 1);
        chk("rst_gated", int'(gated_o), 0);
        chk("rst_cnt", int'(gated_cnt_o), 0);
        rst_ni = 1'b1; en_auto_i = 1'b1; idle_thresh_i = 8'd3;
        step(4);
        chk("thr3_e4_clk_en", int'(clk_en_o), 1);
        step(1);
        chk("thr3_e5_clk_en", int'(clk_en_o), 0);
        chk("thr3_e5_gated", int'(gated_o), 1);
        step(3);
        chk("thr3_cnt", int'(gated_cnt_o), 3);
        wake_req_i = 1'b1;
        step(1);
        chk("wake_e1_clk_en", int'(clk_en_o), 1);
        chk("wake_e1_gated", int'(gated_o), 0);
        chk("wake_e1_ack", int'(wake_ack_o), 0);
        step(1);
        chk("wake_e2_ack", int'(wake_ack_o), 0);
        step(1);
        chk("wake_e3_ack", int'(wake_ack_o), 1);
        wake_req_i = 1'b0; idle_thresh_i = 8'd5;
        step(4);
        busy_i = 1'b1;
        step(1);
        chk("busy_ack", int'(wake_ack_o), 1);
        busy_i = 1'b0;
        step(6);
        chk("thr5_e6_clk_en", int'(clk_en_o), 1);
        step(1);
        chk("thr5_e7_clk_en", int'(clk_en_o), 0);
        test_en_i = 1'b1;
        step(3);
        chk("test_ack", int'(wake_ack_o), 1);
        step(20);
        chk("test_clk_en", int'(clk_en_o), 1);
        test_en_i = 1'b0;
        step(7);
        chk("regate", int'(gated_o), 1);
        step(20);
        chk("sat_cnt", int'(gated_cnt_o), 15);
        stat_clr_i = 1'b1;
        step(1);
        chk("clr_cnt", int'(gated_cnt_o), 0);
        stat_clr_i = 1'b0;
        step(1);
        chk("clr_next", int'(gated_cnt_o), 1);
        wake_req_i = 1'b1;
        step(1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rstw_clk_en", int'(clk_en_o), 1);
        chk("rstw_ack", int'(wake_ack_o), 1);
        chk("rstw_cnt", int'(gated_cnt_o), 0);
        wake_req_i = 1'b0;
        step(1);
        rst_ni = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            step(1);
            en_auto_i = $urandom_range(0, 15) != 0;
            test_en_i = $urandom_range(0, 31) == 0;
            busy_i = $urandom_range(0, 11) == 0;
            stat_clr_i = $urandom_range(0, 63) == 0;
            if ($urandom_range(0, 15) == 0) idle_thresh_i = 8'($urandom_range(0, 6));
            if (wake_req_i && wake_ack_o) wake_req_i = 1'b0;
            else if ($urandom_range(0, 19) == 0) wake_req_i = 1'b1;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_ni = 1'b0;
                #1 rst_ni = 1'b1;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pulp_clock_gate_ctrl.md
PULP_CLOCK_GATE_CTRL -- requirements
Module: pulp_clock_gate_ctrl

Purpose: idle-detect controller generating the enable for a downstream latch-based clock gate. Runs on the free-running (ungated) clock.

Interface
REQ-001 Parameter IDLE_CNT_WIDTH, default 8, SHALL set the idle counter and threshold width.
REQ-002 Parameter WAKE_LAT, default 2, legal range 1..15, SHALL set the number of stabilisation cycles after re-enabling the clock before acknowledging.
REQ-003 Parameter STAT_WIDTH, default 32, SHALL set the gated-cycle statistics counter width.
REQ-004 clk_i  input  1  free-running clock; the only clock in the block.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 en_auto_i  input  1  automatic gating allowed.
REQ-007 test_en_i  input  1  test mode; forbids gating.
REQ-008 busy_i  input  1  gated domain has outstanding work.
REQ-009 wake_req_i  input  1  request for a running clock; held high until wake_ack_o is seen.
REQ-010 idle_thresh_i  input  IDLE_CNT_WIDTH  idle cycles required before gating.
REQ-011 stat_clr_i  input  1  synchronous clear of gated_cnt_o.
REQ-012 clk_en_o  output  1  enable to the clock-gate cell.
REQ-013 gated_o  output  1  clock currently gated.
REQ-014 wake_ack_o  output  1  clock running and stable.
REQ-015 gated_cnt_o  output  STAT_WIDTH  saturating count of cycles spent gated.

Function
REQ-016 Idle condition SHALL be: en_auto_i=1, test_en_i=0, busy_i=0, wake_req_i=0.
REQ-017 FSM SHALL have states RUN, COUNT, GATED and WAKE.
REQ-018 RUN: on idle condition, go to COUNT with idle counter cleared to 0; otherwise stay.
REQ-019 COUNT: if the idle condition is lost, go to RUN and clear the counter; else if counter >= idle_thresh_i, go to GATED; else increment the counter.
REQ-020 The comparison SHALL use the current idle_thresh_i, so lowering it mid-count gates on the next evaluated cycle.
REQ-021 Threshold latency: with continuous idle from cycle 0, clk_en_o SHALL fall at edge N+2, where N = idle_thresh_i (N=0 -> edge 2).
REQ-022 GATED: on busy_i, wake_req_i, test_en_i, or !en_auto_i, go to WAKE with the wake counter at 0; otherwise stay.
REQ-023 WAKE: if wake counter = WAKE_LAT-1, go to RUN; else increment; WAKE SHALL NOT be abortable.
REQ-024 Outputs SHALL be driven directly from flops, with no combinational decode, so clk_en_o is glitch-free.
REQ-025 Output values per state SHALL be: clk_en_o=0 only in GATED; gated_o=1 only in GATED; wake_ack_o=1 only in RUN.
REQ-026 Wake latency: wake_req_i sampled in GATED SHALL give clk_en_o=1 at edge 1 and wake_ack_o=1 at edge WAKE_LAT+1.
REQ-027 wake_req_i sampled in RUN SHALL see wake_ack_o already high, with no state change.
REQ-028 wake_req_i sampled in COUNT SHALL return the FSM to RUN, with wake_ack_o=1 at the next edge.
REQ-029 gated_cnt_o SHALL increment by 1 on each cycle in which gated_o=1.
REQ-030 gated_cnt_o SHALL saturate at all-ones.
REQ-031 stat_clr_i SHALL take priority over increment and set gated_cnt_o to 0 at the next edge.
REQ-032 Simultaneous busy_i and wake_req_i SHALL be treated identically to either one alone.

Reset
REQ-033 Asserting rst_ni low SHALL immediately (asynchronously) force state RUN and set clk_en_o=1, gated_o=0, wake_ack_o=1.
REQ-034 Asserting rst_ni low SHALL clear both the idle and wake counters and set gated_cnt_o=0.
REQ-035 Reset asserted in GATED or WAKE SHALL re-enable the clock without waiting for WAKE_LAT.
REQ-036 The first transition out of RUN SHALL occur no earlier than the first clk_i edge after rst_ni deassertion.

Verification
REQ-037 Continuous idle with idle_thresh_i=3 -> clk_en_o falls at edge 5, gated_o=1, and gated_cnt_o counts one per cycle thereafter.
REQ-038 Idle with thresh=5 and busy_i pulsed at count 3 -> return to RUN, clk_en_o never falls, and a fresh 7-edge idle run is needed to gate.
REQ-039 In GATED with WAKE_LAT=2, raise wake_req_i -> clk_en_o=1 at edge 1, wake_ack_o=1 at edge 3, gated_o=0 at edge 1.
REQ-040 test_en_i=1 while GATED -> WAKE then RUN, and no further gating until test_en_i=0.
REQ-041 Preload gated_cnt_o to all-ones via a long gated run with STAT_WIDTH=4 -> holds at 15; stat_clr_i together with gated -> 0.
REQ-042 rst_ni asserted mid-WAKE -> clk_en_o=1 and wake_ack_o=1 asynchronously, and the counters read 0.
